packet_distributer_mc: RTL
==========================

Name: packet_distributer_mc

Overview:
- N-channel successor to the 2-way request/ACK packet distributer in the transport subsystem.
- Steers each inbound packet to one of NUM_CH output channels, chosen by a runtime-programmable opcode-to-channel table.
- Forwards the first beat with zero bubble, discards packets mapped to an unused channel, and keeps per-channel/drop/error statistics.
- Sits between the receive parser and the request/ACK/CNP handling engines.

Parameters:
- NUM_CH, 4, number of output channels (2..8).
- CH_W, 3, channel index width; must satisfy 2^CH_W > NUM_CH so a drop code exists.
- HEAD_WIDTH, `PKT_HEAD_WIDTH, head bus width.
- DATA_WIDTH, `PKT_DATA_WIDTH, data bus width.
- OPC_LSB, opcode LSB within head (the `OPCODE_OFFSET field, 5 bits wide).
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- i_recv_valid / i_recv_start / i_recv_last  in  1 each  inbound beat qualifiers.
- iv_recv_head  in  HEAD_WIDTH  inbound head, stable for the whole packet.
- iv_recv_data  in  DATA_WIDTH  inbound data.
- o_recv_ready  out  1  inbound ready.
- o_out_valid / o_out_start / o_out_last  out  NUM_CH each  per-channel qualifiers.
- ov_out_head  out  NUM_CH*HEAD_WIDTH  per-channel head; channel k occupies slice k.
- ov_out_data  out  NUM_CH*DATA_WIDTH  per-channel data; channel k occupies slice k.
- i_out_ready  in  NUM_CH  per-channel ready.
- i_cfg_wr_en  in  1  route table write strobe.
- iv_cfg_wr_opc  in  5  table index to write.
- iv_cfg_wr_ch  in  CH_W  channel value; any value >= NUM_CH means drop.
- ov_pkt_cnt  out  NUM_CH*CNT_W  packets completed per channel.
- ov_drop_cnt  out  CNT_W  packets discarded by route.
- ov_err_cnt  out  CNT_W  orphan beats discarded.
- o_err_pulse  out  1  one-cycle pulse for each orphan beat.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all counters 0; o_err_pulse=0.
  - Route table: entry `ACKNOWLEDGE=1; all other entries 0. This matches the legacy 2-way map.
- Outputs:
  - All out-path outputs are combinational.
  - Unselected channels drive valid, start and last = 0, and head and data = 0.
- Handshake and transfers:
  - A beat transfers when valid && ready.
  - A packet completes on the transfer of its last beat.
- State IDLE:
  - r = table[opcode of iv_recv_head]. r is captured into cur_ch whenever i_recv_valid=1.
  - valid && start && r<NUM_CH:
    - Channel r is driven with the input beat in the same cycle; o_recv_ready = i_out_ready[r].
    - Next state: IDLE if the beat is accepted with last=1, otherwise FWD. This includes the case where the start beat is not yet accepted.
  - valid && start && r>=NUM_CH:
    - o_recv_ready=1 and no channel is driven.
    - If last=1, stay IDLE and ov_drop_cnt increments. Otherwise go to DROP.
  - valid && !start:
    - Orphan beat: o_recv_ready=1, beat discarded, o_err_pulse=1 next cycle, ov_err_cnt increments.
    - Stay IDLE.
  - !valid: o_recv_ready=0.
- State FWD:
  - Route comes from cur_ch only; table writes have no effect on the packet in flight.
  - o_recv_ready = i_out_ready[cur_ch].
  - Leave to IDLE on transfer of the last beat; ov_pkt_cnt[cur_ch] increments on that cycle.
  - A start=1 beat inside FWD is forwarded as data; no re-route.
- State DROP:
  - o_recv_ready=1.
  - On valid && last, go to IDLE and ov_drop_cnt increments.
- Counters wrap modulo 2^CNT_W with no saturation.
- Single-beat packets (start=last=1) complete in one cycle when the target channel is ready.
- Back-to-back packets: no idle bubble is required between the last beat and the next start beat.
- Table write:
  - Takes effect at the next clk edge.
  - A write in the same cycle as an IDLE lookup does not affect that lookup; the lookup sees the old value.
- Reset mid-packet: state returns to IDLE. Remaining beats of the interrupted packet arrive as orphans and are counted as errors.
- Latency: 0 cycles, combinational pass-through. No buffering.

Decomposition:
- Shared package transport_subsystem_def.vh holds:
  - state encodings DIS_IDLE/DIS_FWD/DIS_DROP;
  - the default route table init constant;
  - the opcode field width.
- One natural sub-module: dist_route_table, the 32 x CH_W register file with synchronous write, combinational read and reset init.
- FSM, datapath muxing and counters stay in the top module.

Test Plan:
- Route ACK: default table, NUM_CH=4. 3-beat packet with opcode `ACKNOWLEDGE, all ready=1 → channel 1 valid on cycles 0-2 with matching head/data; other channels 0; ov_pkt_cnt[1]=1.
- Reprogram: write opcode 0x04 → ch 3, then send a 1-beat 0x04 packet → forwarded on ch 3 in the same cycle; ov_pkt_cnt[3]=1.
- Backpressure: 4-beat packet to ch 0 with i_out_ready[0] toggling 1,0,0,1,... → o_recv_ready mirrors it; every beat is delivered exactly once; a table write of the opcode mid-packet does not change the route.
- Drop: map 0x0A to 7, send a 5-beat 0x0A packet → o_recv_ready=1 throughout, no channel valid, ov_drop_cnt=1.
- Orphan: in IDLE, valid=1 with start=0 for 2 beats → two o_err_pulse cycles, ov_err_cnt=2, no channel valid.
- Back-to-back, then reset mid-packet: 1-beat packets to ch 0, 1, 2 on consecutive cycles → one per cycle, no bubble. Then assert rst=0 during beat 2 of a 4-beat packet → IDLE, counters 0; the following 2 beats count as ov_err_cnt=2.

Source files
------------

// File: rtl/packet_distributer_mc_pkg.sv
// rtl/packet_distributer_mc_pkg.sv - shared encodings and constants for the packet distributer
package packet_distributer_mc_pkg;

    // Opcode field and route table geometry
    localparam int OPC_W       = 5;
    localparam int TABLE_DEPTH = 1 << OPC_W;

    // Transport subsystem defaults
    localparam int PKT_HEAD_WIDTH = 32;
    localparam int PKT_DATA_WIDTH = 32;
    localparam int OPCODE_OFFSET  = 8;

    localparam logic [OPC_W-1:0] OPC_ACKNOWLEDGE = 5'h11;

    typedef enum logic [1:0] {
        DIS_IDLE = 2'd0,
        DIS_FWD  = 2'd1,
        DIS_DROP = 2'd2
    } dist_state_e;

    // Reset contents of the route table: acknowledges go to channel 1,
    // everything else to channel 0, same as the legacy 2-way map.
    function automatic int route_init(input int idx);
        return (idx == int'(OPC_ACKNOWLEDGE)) ? 1 : 0;
    endfunction

endpackage

// File: rtl/packet_distributer_mc_route_table.sv
// rtl/packet_distributer_mc_route_table.sv - opcode-to-channel register file
//
// Ports:
//   clk, rst        clock, synchronous active-low reset (loads default map)
//   wr_en/opc/ch    synchronous write of one entry
//   rd_opc, rd_ch   combinational lookup (sees the value before any same-cycle write)
module packet_distributer_mc_route_table
    import packet_distributer_mc_pkg::*;
#(
    parameter int CH_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [OPC_W-1:0] wr_opc,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [OPC_W-1:0] rd_opc,
    output logic [CH_W-1:0]  rd_ch
);

    logic [CH_W-1:0] entries [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                entries[i] <= CH_W'(route_init(i));
            end
        end else if (wr_en) begin
            entries[wr_opc] <= wr_ch;
        end
    end

    assign rd_ch = entries[rd_opc];

endmodule

// File: rtl/packet_distributer_mc.sv
// rtl/packet_distributer_mc.sv - N-channel opcode-routed packet distributer
//
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   i_recv_*/iv_recv_*/o_recv_ready inbound beat stream
//   o_out_*/ov_out_*/i_out_ready    per-channel outbound streams (slice k = channel k)
//   i_cfg_wr_en/iv_cfg_wr_opc/ch    route table write port
//   ov_pkt_cnt/ov_drop_cnt/ov_err_cnt, o_err_pulse  statistics
module packet_distributer_mc
    import packet_distributer_mc_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 3,
    parameter int HEAD_WIDTH = PKT_HEAD_WIDTH,
    parameter int DATA_WIDTH = PKT_DATA_WIDTH,
    parameter int OPC_LSB    = OPCODE_OFFSET,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_recv_valid,
    input  logic                         i_recv_start,
    input  logic                         i_recv_last,
    input  logic [HEAD_WIDTH-1:0]        iv_recv_head,
    input  logic [DATA_WIDTH-1:0]        iv_recv_data,
    output logic                         o_recv_ready,
    output logic [NUM_CH-1:0]            o_out_valid,
    output logic [NUM_CH-1:0]            o_out_start,
    output logic [NUM_CH-1:0]            o_out_last,
    output logic [NUM_CH*HEAD_WIDTH-1:0] ov_out_head,
    output logic [NUM_CH*DATA_WIDTH-1:0] ov_out_data,
    input  logic [NUM_CH-1:0]            i_out_ready,
    input  logic                         i_cfg_wr_en,
    input  logic [OPC_W-1:0]             iv_cfg_wr_opc,
    input  logic [CH_W-1:0]              iv_cfg_wr_ch,
    output logic [NUM_CH*CNT_W-1:0]      ov_pkt_cnt,
    output logic [CNT_W-1:0]             ov_drop_cnt,
    output logic [CNT_W-1:0]             ov_err_cnt,
    output logic                         o_err_pulse
);

    dist_state_e       state;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   route;
    logic              route_ok;
    logic              sel_en;
    logic [CH_W-1:0]   sel_ch;
    logic [NUM_CH-1:0] sel_onehot;
    logic              xfer;
    logic              pkt_done;
    logic              drop_done;
    logic              orphan;
    logic              err_pulse;
    logic [CNT_W-1:0]  pkt_cnt [NUM_CH];
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;

    packet_distributer_mc_route_table #(
        .CH_W (CH_W)
    ) u_route_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (i_cfg_wr_en),
        .wr_opc (iv_cfg_wr_opc),
        .wr_ch  (iv_cfg_wr_ch),
        .rd_opc (iv_recv_head[OPC_LSB +: OPC_W]),
        .rd_ch  (route)
    );

    // Any table value at or above NUM_CH is a drop code
    assign route_ok = (route < CH_W'(NUM_CH));

    // Channel selection: a routed start beat in IDLE goes out on the looked-up
    // channel in the same cycle; inside a packet only the latched channel counts.
    always_comb begin
        sel_en = 1'b0;
        sel_ch = route;
        case (state)
            DIS_IDLE: sel_en = i_recv_valid && i_recv_start && route_ok;
            DIS_FWD: begin
                sel_en = 1'b1;
                sel_ch = cur_ch;
            end
            default: sel_en = 1'b0;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sel_onehot[k] = sel_en && (sel_ch == CH_W'(k));
        end
    end

    // Unrouted cases (drop, orphan) always accept so the parser never stalls on them
    always_comb begin
        if (sel_en) begin
            o_recv_ready = |(i_out_ready & sel_onehot);
        end else begin
            o_recv_ready = (state == DIS_DROP) || ((state == DIS_IDLE) && i_recv_valid);
        end
    end

    assign xfer      = i_recv_valid && o_recv_ready;
    assign pkt_done  = sel_en && xfer && i_recv_last;
    assign orphan    = (state == DIS_IDLE) && i_recv_valid && !i_recv_start;
    assign drop_done = i_recv_valid && i_recv_last &&
                       (((state == DIS_IDLE) && i_recv_start && !route_ok) ||
                        (state == DIS_DROP));

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_out
            assign o_out_valid[g] = sel_onehot[g] && i_recv_valid;
            assign o_out_start[g] = sel_onehot[g] && i_recv_valid && i_recv_start;
            assign o_out_last[g]  = sel_onehot[g] && i_recv_valid && i_recv_last;
            assign ov_out_head[g*HEAD_WIDTH +: HEAD_WIDTH] = sel_onehot[g] ? iv_recv_head : '0;
            assign ov_out_data[g*DATA_WIDTH +: DATA_WIDTH] = sel_onehot[g] ? iv_recv_data : '0;
            assign ov_pkt_cnt[g*CNT_W +: CNT_W] = pkt_cnt[g];
        end
    endgenerate

    assign ov_drop_cnt = drop_cnt;
    assign ov_err_cnt  = err_cnt;
    assign o_err_pulse = err_pulse;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= DIS_IDLE;
            cur_ch    <= '0;
            drop_cnt  <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                pkt_cnt[k] <= '0;
            end
        end else begin
            err_pulse <= orphan;
            if (orphan) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (drop_done) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (pkt_done && sel_onehot[k]) begin
                    pkt_cnt[k] <= pkt_cnt[k] + 1'b1;
                end
            end

            case (state)
                DIS_IDLE: begin
                    if (i_recv_valid) begin
                        cur_ch <= route;
                    end
                    if (i_recv_valid && i_recv_start) begin
                        if (route_ok) begin
                            // An unaccepted start beat still opens the packet;
                            // it is re-presented and forwarded from FWD.
                            if (!(xfer && i_recv_last)) begin
                                state <= DIS_FWD;
                            end
                        end else if (!i_recv_last) begin
                            state <= DIS_DROP;
                        end
                    end
                end
                DIS_FWD: begin
                    if (xfer && i_recv_last) begin
                        state <= DIS_IDLE;
                    end
                end
                DIS_DROP: begin
                    if (i_recv_valid && i_recv_last) begin
                        state <= DIS_IDLE;
                    end
                end
                default: state <= DIS_IDLE;
            endcase
        end
    end

endmodule
